// File: rtl/ilkn_pkg.sv
// Interlaken lane constants shared by the transmit scrambler/encoder.
// Word classification helper for the 64b/67b control types.
package ilkn_pkg;
  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  localparam logic [5:0] TYPE_SYNC        = 6'b011110;
  localparam logic [5:0] TYPE_SCRAM_STATE = 6'b001010;

  localparam int LFSR_TAP_HI = 58;
  localparam int LFSR_TAP_LO = 39;

  localparam logic [57:0] LFSR_SEED_DEFAULT = 58'h1D2C_3B4A_5968_7;

  typedef enum logic [1:0] {
    WORD_DATA,
    WORD_SYNC,
    WORD_STATE
  } word_kind_e;

  function automatic word_kind_e classify(
    input logic [1:0] hdr,
    input logic [5:0] typ
  );
    if (hdr != HDR_CTRL) return WORD_DATA;
    unique case (typ)
      TYPE_SYNC:        return WORD_SYNC;
      TYPE_SCRAM_STATE: return WORD_STATE;
      default:          return WORD_DATA;
    endcase
  endfunction
endpackage

// File: rtl/ilkn_scrambler58.sv
// x^58+x^39+1 additive scrambler, 64 keystream bits per advance.
// keystream[63] is the first bit produced after the current state.
module ilkn_scrambler58
  import ilkn_pkg::*;
#(
  parameter logic [57:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [57:0] state_out,
  output logic [63:0] keystream
);
  logic [57:0] r_state;
  logic [57:0] w_s;
  logic [63:0] w_ks;
  logic        w_fb;

  always_comb begin
    w_s  = r_state;
    w_ks = '0;
    w_fb = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w_fb = w_s[LFSR_TAP_HI-1] ^ w_s[LFSR_TAP_LO-1];
      w_ks[63-i] = w_fb;
      w_s = {w_s[56:0], w_fb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (advance) begin
      r_state <= w_s;
    end
  end

  assign state_out = r_state;
  assign keystream = w_ks;
endmodule

// File: rtl/tx_scramble_encoder.sv
// Interlaken TX: scramble + state insertion, then 67th-bit
// running-disparity inversion. Two register stages.
module tx_scramble_encoder
  import ilkn_pkg::*;
#(
  parameter logic [57:0] SCRAMBLER_SEED  = LFSR_SEED_DEFAULT,
  parameter bit          SCRAMBLE_BYPASS = 1'b0,
  parameter int          RD_WIDTH        = 9
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET_N,
  input  logic [63:0] DATA_IN,
  input  logic [1:0]  HEADER_IN,
  input  logic        DATA_IN_VALID,
  output logic [63:0] DATA_OUT,
  output logic [2:0]  HEADER_OUT,
  output logic        DATA_OUT_VALID
);
  localparam int RD_MAX = 2 ** (RD_WIDTH - 1) - 1;
  localparam int RD_MIN = -(2 ** (RD_WIDTH - 1));

  logic [57:0] w_lfsr_state;
  logic [63:0] w_keystream;
  logic [63:0] w_key_mask;
  word_kind_e  w_kind;
  logic [63:0] w_s1_data;

  logic        r_s1_valid;
  logic [63:0] r_s1_data;
  logic [1:0]  r_s1_hdr;

  int          w_pop_d;
  int          w_pop_h;
  int          w_w;
  int          w_rd_ext;
  logic        w_inv;
  int          w_pop67;
  int          w_rd_sum;

  logic                       r_valid;
  logic [63:0]                r_data;
  logic [2:0]                 r_hdr;
  logic signed [RD_WIDTH-1:0] r_rd;

  ilkn_scrambler58 #(
    .SEED (SCRAMBLER_SEED)
  ) u_scr (
    .clk       (USER_CLK),
    .rst_n     (SYSTEM_RESET_N),
    .advance   (DATA_IN_VALID),
    .state_out (w_lfsr_state),
    .keystream (w_keystream)
  );

  assign w_key_mask = SCRAMBLE_BYPASS ? '0 : w_keystream;
  assign w_kind = classify(HEADER_IN, DATA_IN[63:58]);

  always_comb begin
    w_s1_data = DATA_IN ^ w_key_mask;
    unique case (w_kind)
      WORD_SYNC:  w_s1_data = DATA_IN;
      WORD_STATE: w_s1_data = {DATA_IN[63:58], w_lfsr_state};
      default:    w_s1_data = DATA_IN ^ w_key_mask;
    endcase
  end

  always_ff @(posedge USER_CLK) begin
    if (!SYSTEM_RESET_N) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_hdr   <= '0;
    end else begin
      r_s1_valid <= DATA_IN_VALID;
      r_s1_data  <= DATA_IN_VALID ? w_s1_data : '0;
      r_s1_hdr   <= DATA_IN_VALID ? HEADER_IN : '0;
    end
  end

  // Word disparity and emitted disparity as signed ints.
  assign w_pop_d  = $countones(r_s1_data);
  assign w_pop_h  = $countones(r_s1_hdr);
  assign w_w      = 2 * (w_pop_d + w_pop_h) - 66;
  assign w_rd_ext = int'(r_rd);
  assign w_inv    = (w_rd_ext != 0) && (w_w != 0) &&
                    ((w_w < 0) == (w_rd_ext < 0));
  assign w_pop67  = w_inv ? (w_pop_h + (64 - w_pop_d) + 1)
                          : (w_pop_h + w_pop_d);
  assign w_rd_sum = w_rd_ext + 2 * w_pop67 - 67;

  always_ff @(posedge USER_CLK) begin
    if (!SYSTEM_RESET_N) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_hdr   <= '0;
      r_rd    <= '0;
    end else if (r_s1_valid) begin
      r_valid <= 1'b1;
      r_data  <= w_inv ? ~r_s1_data : r_s1_data;
      r_hdr   <= {w_inv, r_s1_hdr};
      r_rd    <= RD_WIDTH'(w_rd_sum);
    end else begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_hdr   <= '0;
    end
  end

  assign DATA_OUT       = r_data;
  assign HEADER_OUT     = r_hdr;
  assign DATA_OUT_VALID = r_valid;

  a_hdr: assert property (@(posedge USER_CLK) disable iff (!SYSTEM_RESET_N)
    DATA_IN_VALID |-> (HEADER_IN == HDR_DATA || HEADER_IN == HDR_CTRL))
    else $error("tx_scramble_encoder: illegal header %b", HEADER_IN);

  a_rd: assert property (@(posedge USER_CLK) disable iff (!SYSTEM_RESET_N)
    r_s1_valid |-> (w_rd_sum >= RD_MIN && w_rd_sum <= RD_MAX))
    else $error("tx_scramble_encoder: running disparity overflow");
endmodule

// File: tb/tb_tx_scramble_encoder.sv
// Bench: scrambled and bypass instances checked every cycle against
// a keystream-recurrence model, plus table and corner sequences.
module tb_tx_scramble_encoder;
  localparam logic [57:0] SEED = 58'h1D2C_3B4A_5968_7;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [2:0]  h;
  } out_t;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  h;
    logic [63:0] ed;
    logic [2:0]  eh;
  } vec_t;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  bit        rst_n;
  bit [63:0] din;
  bit [1:0]  hin;
  bit        vin;

  logic [63:0] dout_s, dout_b;
  logic [2:0]  hout_s, hout_b;
  logic        vout_s, vout_b;

  int  nchecks = 0;
  int  nerr = 0;
  bit  chk_en = 1'b0;

  tx_scramble_encoder #(
    .SCRAMBLER_SEED  (SEED),
    .SCRAMBLE_BYPASS (1'b0),
    .RD_WIDTH        (9)
  ) dut_s (
    .USER_CLK       (clk),
    .SYSTEM_RESET_N (rst_n),
    .DATA_IN        (din),
    .HEADER_IN      (hin),
    .DATA_IN_VALID  (vin),
    .DATA_OUT       (dout_s),
    .HEADER_OUT     (hout_s),
    .DATA_OUT_VALID (vout_s)
  );

  tx_scramble_encoder #(
    .SCRAMBLER_SEED  (SEED),
    .SCRAMBLE_BYPASS (1'b1),
    .RD_WIDTH        (9)
  ) dut_b (
    .USER_CLK       (clk),
    .SYSTEM_RESET_N (rst_n),
    .DATA_IN        (din),
    .HEADER_IN      (hin),
    .DATA_IN_VALID  (vin),
    .DATA_OUT       (dout_b),
    .HEADER_OUT     (hout_b),
    .DATA_OUT_VALID (vout_b)
  );

  // Model: keystream k[n] = k[n-58] ^ k[n-39], circular history.
  bit   kbuf[2][58];
  int   kptr[2];
  int   mrd[2];
  out_t pend[2];
  out_t expv[2];
  out_t zero_o = '{1'b0, 64'd0, 3'd0};

  function automatic void mreset(input int i);
    logic [57:0] sd;
    sd = SEED;
    kptr[i] = 0;
    for (int j = 0; j < 58; j++) kbuf[i][57-j] = sd[j];
    mrd[i] = 0;
  endfunction

  function automatic logic [57:0] mstate(input int i);
    logic [57:0] s;
    for (int j = 0; j < 58; j++) s[j] = kbuf[i][(kptr[i] + 57 - j) % 58];
    return s;
  endfunction

  function automatic logic [63:0] mkey(input int i);
    logic [63:0] ks;
    bit nb;
    for (int b = 0; b < 64; b++) begin
      nb = kbuf[i][kptr[i]] ^ kbuf[i][(kptr[i] + 19) % 58];
      kbuf[i][kptr[i]] = nb;
      kptr[i] = (kptr[i] + 1) % 58;
      ks[63-b] = nb;
    end
    return ks;
  endfunction

  function automatic out_t mword(input int i, input logic [63:0] d,
                                 input logic [1:0] h);
    out_t o;
    logic [57:0] st;
    logic [63:0] ks, x;
    int ones, w;
    bit inv;
    st = mstate(i);
    ks = mkey(i);
    if (h == 2'b10 && d[63:58] == 6'b011110) x = d;
    else if (h == 2'b10 && d[63:58] == 6'b001010) x = {d[63:58], st};
    else x = (i == 1) ? d : (d ^ ks);
    ones = $countones(h) + $countones(x);
    w = 2 * ones - 66;
    inv = (mrd[i] != 0) && (w != 0) && ((w > 0) == (mrd[i] > 0));
    if (inv) begin
      x = ~x;
      ones = $countones(h) + $countones(x) + 1;
    end
    mrd[i] = mrd[i] + 2 * ones - 67;
    o.v = 1'b1;
    o.d = x;
    o.h = {inv, h};
    return o;
  endfunction

  function automatic logic [57:0] seed_adv(input int n);
    bit b[$];
    logic [57:0] sd, s;
    sd = SEED;
    for (int j = 57; j >= 0; j--) b.push_back(sd[j]);
    for (int k = 0; k < n; k++)
      b.push_back(b[b.size()-58] ^ b[b.size()-39]);
    for (int j = 0; j < 58; j++) s[j] = b[b.size()-1-j];
    return s;
  endfunction

  task automatic check(input string name, input logic [67:0] act,
                       input logic [67:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mreset(i);
        pend[i] = zero_o;
        expv[i] = zero_o;
      end else begin
        expv[i] = pend[i];
        pend[i] = vin ? mword(i, din, hin) : zero_o;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("scr_out", {vout_s, hout_s, dout_s},
            {expv[0].v, expv[0].h, expv[0].d});
      check("byp_out", {vout_b, hout_b, dout_b},
            {expv[1].v, expv[1].h, expv[1].d});
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic rnd_word();
    din = rnd64();
    hin = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    if (hin == 2'b10) begin
      case ($urandom_range(0, 3))
        0: din[63:58] = 6'b011110;
        1: din[63:58] = 6'b001010;
        default: ;
      endcase
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; vin = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[8];
  logic [63:0] r;

  initial begin
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'h0, 3'b101};
    tbl[2] = '{64'h0, 2'b01, 64'h0, 3'b001};
    tbl[3] = '{64'h0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 3'b101};
    tbl[4] = '{64'hAAAA_AAAA_AAAA_AAAA, 2'b10, 64'hAAAA_AAAA_AAAA_AAAA, 3'b010};
    tbl[5] = '{64'h00FF_FFFF_FFFF_FFFF, 2'b01, 64'h00FF_FFFF_FFFF_FFFF, 3'b001};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'h0, 3'b101};
    tbl[7] = '{64'h0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 3'b101};

    rst_n = 1'b0; vin = 1'b0; din = '0; hin = 2'b01;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Bypass disparity table, one word at a time.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      din = tbl[k].d; hin = tbl[k].h; vin = 1'b1;
      @(posedge clk); #1;
      vin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d", k), {vout_b, hout_b, dout_b},
            {1'b1, tbl[k].eh, tbl[k].ed});
    end

    // Sync then state word straight after reset.
    pulse_reset();
    @(posedge clk); #1;
    din = 64'h78F6_78F6_78F6_78F6; hin = 2'b10; vin = 1'b1;
    @(posedge clk); #1;
    din = 64'h2800_0000_0000_0000; hin = 2'b10;
    @(posedge clk); #1;
    vin = 1'b0;
    @(negedge clk);
    check("sync_word", {vout_s, hout_s, dout_s},
          {1'b1, 3'b010, 64'h78F6_78F6_78F6_78F6});
    @(posedge clk);
    @(negedge clk);
    r = hout_s[2] ? ~dout_s : dout_s;
    check("state_word", {4'd0, r}, {4'd0, 6'b001010, seed_adv(64)});

    // Random words, valid every cycle.
    for (int k = 0; k < 256; k++) begin
      @(posedge clk); #1;
      rnd_word(); vin = 1'b1;
    end

    // Framer cadence: 64 valid of every 67 cycles.
    for (int c = 0; c < 3 * 67; c++) begin
      @(posedge clk); #1;
      rnd_word();
      vin = ((c % 67) < 64);
    end

    // One-cycle reset in the middle of a burst.
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      rnd_word(); vin = 1'b1;
      rst_n = (k != 20);
      @(negedge clk);
      if (k == 21) check("rst_gap0", {67'd0, vout_s}, 68'd0);
      if (k == 22) check("rst_gap1", {67'd0, vout_s}, 68'd0);
      if (k == 23) check("rst_resume", {67'd0, vout_s}, 68'd1);
    end

    // Alternating light/heavy words for the disparity path.
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      hin = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      if (k % 2 == 0) din = rnd64() & rnd64() & rnd64();
      else din = rnd64() | rnd64() | rnd64();
      if (hin == 2'b10 && din[63:58] inside {6'b011110, 6'b001010})
        din[63:58] = 6'b111111;
      vin = ($urandom_range(0, 7) != 0);
    end

    @(posedge clk); #1;
    vin = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
